// File: rtl/uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions, FSM state encoding and the effective-divisor helper.
package uart_tx_pkg;

    localparam logic [3:0] OFF_TXDATA  = 4'h0;
    localparam logic [3:0] OFF_STATUS  = 4'h4;
    localparam logic [3:0] OFF_DIVISOR = 4'h8;
    localparam logic [3:0] OFF_IRQ_EN  = 4'hC;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_EMPTY   = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 8;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    // A programmed divisor of zero still produces a one-cycle bit period.
    function automatic logic [15:0] eff_div(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/uart_tx_sync_fifo.sv
// Single-clock FIFO with show-ahead output: dout always presents the head entry,
// so a consumer can take it on the same edge it asserts pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    wr_ptr_reg;
    logic [CW-1:0]    rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    // Push is judged on the state before the edge: a full FIFO drops even if popped now.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + CW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg[AW-1:0]] <= din;
    end

    assign dout  = mem[rd_ptr_reg[AW-1:0]];
    assign count = wr_ptr_reg - rd_ptr_reg;
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: CPU stores feed a TX FIFO, an FSM shifts
// bytes out at a programmable bit period. Optional interrupt output under UART_TX_IRQ_EN.
import uart_tx_pkg::*;

module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    input  logic        write_enable,
    output logic [31:0] read_data,
    output logic        tx
`ifdef UART_TX_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          sel;
    logic [3:0]    off;
    logic          wr_txdata;
    logic          wr_status;
    logic          wr_divisor;
    logic          busy;

    logic          fifo_pop;
    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    logic [1:0]    state_reg,   state_next;
    logic [7:0]    shift_reg,   shift_next;
    logic [2:0]    bit_idx_reg, bit_idx_next;
    logic [15:0]   cnt_reg,     cnt_next;
    logic [15:0]   div_lat_reg, div_lat_next;
    logic          tx_reg,      tx_next;
    logic [15:0]   divisor_reg;
    logic          ovf_reg;
    logic [15:0]   div_eff;
    logic [31:0]   status_word;
    logic          unused_bits;

    assign sel        = (addr[31:4] == BASE_ADDR[31:4]);
    assign off        = addr[3:0];
    assign wr_txdata  = sel & write_enable & (off == OFF_TXDATA);
    assign wr_status  = sel & write_enable & (off == OFF_STATUS);
    assign wr_divisor = sel & write_enable & (off == OFF_DIVISOR);
    assign busy       = (state_reg != IDLE);
    assign div_eff    = eff_div(divisor_reg);
    assign unused_bits = ^write_data[31:16];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .srst  (rst),
        .push  (wr_txdata),
        .pop   (fifo_pop),
        .din   (write_data[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // tx is registered and loaded on the transition edge, so each level lasts exactly div cycles.
    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_idx_next = bit_idx_reg;
        cnt_next     = cnt_reg;
        div_lat_next = div_lat_reg;
        tx_next      = tx_reg;
        fifo_pop     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop     = 1'b1;
                    shift_next   = fifo_dout;
                    div_lat_next = div_eff;
                    cnt_next     = div_eff - 16'd1;
                    tx_next      = 1'b0;
                    state_next   = START;
                end
            end
            START: begin
                if (cnt_reg == 16'd0) begin
                    cnt_next     = div_lat_reg - 16'd1;
                    bit_idx_next = 3'd0;
                    tx_next      = shift_reg[0];
                    state_next   = DATA;
                end else begin
                    cnt_next = cnt_reg - 16'd1;
                end
            end
            DATA: begin
                if (cnt_reg == 16'd0) begin
                    cnt_next     = div_lat_reg - 16'd1;
                    bit_idx_next = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == 3'd7) begin
                        tx_next    = 1'b1;
                        state_next = STOP;
                    end else begin
                        shift_next = {1'b0, shift_reg[7:1]};
                        tx_next    = shift_reg[1];
                    end
                end else begin
                    cnt_next = cnt_reg - 16'd1;
                end
            end
            default: begin
                if (cnt_reg == 16'd0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg - 16'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            shift_reg   <= 8'd0;
            bit_idx_reg <= 3'd0;
            cnt_reg     <= 16'd0;
            div_lat_reg <= 16'd1;
            tx_reg      <= 1'b1;
            divisor_reg <= DEFAULT_DIV;
            ovf_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bit_idx_reg <= bit_idx_next;
            cnt_reg     <= cnt_next;
            div_lat_reg <= div_lat_next;
            tx_reg      <= tx_next;
            if (wr_divisor) divisor_reg <= write_data[15:0];
            // A new overflow wins over a simultaneous write-1-to-clear.
            if (wr_txdata && fifo_full) begin
                ovf_reg <= 1'b1;
            end else if (wr_status && write_data[STAT_OVF]) begin
                ovf_reg <= 1'b0;
            end
        end
    end

    assign tx = tx_reg;

    always_comb begin
        status_word                              = '0;
        status_word[STAT_BUSY]                   = busy;
        status_word[STAT_FULL]                   = fifo_full;
        status_word[STAT_EMPTY]                  = fifo_empty;
        status_word[STAT_OVF]                    = ovf_reg;
        status_word[STAT_CNT_LSB+7:STAT_CNT_LSB] = 8'(fifo_count);
    end

`ifdef UART_TX_IRQ_EN
    logic [1:0] irq_en_reg;
    logic       irq_reg;
    logic       wr_irq_en;

    assign wr_irq_en = sel & write_enable & (off == OFF_IRQ_EN);

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en_reg <= 2'b00;
            irq_reg    <= 1'b0;
        end else begin
            if (wr_irq_en) irq_en_reg <= write_data[1:0];
            irq_reg <= (irq_en_reg[0] & fifo_empty & ~busy) | (irq_en_reg[1] & ovf_reg);
        end
    end

    assign irq = irq_reg;
`endif

    always_comb begin
        read_data = '0;
        if (sel) begin
            case (off)
                OFF_STATUS:  read_data = status_word;
                OFF_DIVISOR: read_data = {16'd0, divisor_reg};
`ifdef UART_TX_IRQ_EN
                OFF_IRQ_EN:  read_data = {30'd0, irq_en_reg};
`endif
                default:     read_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Scoreboard bench for uart_tx_mmio: stimulus queues expected frames, a tx-line
// monitor checks every cycle of each frame. Define UART_TX_IRQ_EN for the irq build.
module tb_uart_tx_mmio;

    localparam logic [31:0] A_TXDATA  = 32'h1000_0000;
    localparam logic [31:0] A_STATUS  = 32'h1000_0004;
    localparam logic [31:0] A_DIVISOR = 32'h1000_0008;
    localparam logic [31:0] A_IRQ_EN  = 32'h1000_000C;

    typedef struct {
        logic [7:0] data;
        int         div;
    } frame_t;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic        write_enable;
    logic [31:0] read_data;
    logic        tx;
`ifdef UART_TX_IRQ_EN
    logic        irq;
`endif

    int     checks = 0;
    int     errors = 0;
    frame_t exp_q[$];

    uart_tx_mmio dut (
        .clk          (clk),
        .rst          (rst),
        .addr         (addr),
        .write_data   (write_data),
        .write_enable (write_enable),
        .read_data    (read_data),
        .tx           (tx)
`ifdef UART_TX_IRQ_EN
        ,
        .irq          (irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr         = a;
        write_data   = d;
        write_enable = 1'b1;
        tick();
        write_enable = 1'b0;
        $display("write addr=0x%08h data=0x%08h", a, d);
    endtask

    task automatic reg_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(name, read_data, exp);
    endtask

    task automatic send(input logic [7:0] b, input int div, input bit accept);
        frame_t f;
        if (accept) begin
            f.data = b;
            f.div  = div;
            exp_q.push_back(f);
        end
        bus_write(A_TXDATA, {24'd0, b});
    endtask

    // Called right after the push edge: checks start latency and the busy window length.
    task automatic send_timed(input logic [7:0] b, input int div, input int exp_busy);
        int n;
        send(b, div, 1'b1);
        check("tx_idle_at_push", {31'd0, tx}, 32'd1);
        reg_check("status_after_push", A_STATUS, 32'h0000_0100);
        tick();
        check("tx_start_latency", {31'd0, tx}, 32'd0);
        reg_check("status_frame_start", A_STATUS, 32'h0000_0005);
        n = 1;
        for (int i = 0; i < 2000; i++) begin
            tick();
            addr = A_STATUS;
            #1;
            if (read_data[0]) n++;
            else break;
        end
        check("busy_cycles", n, exp_busy);
        reg_check("status_after_frame", A_STATUS, 32'h0000_0004);
    endtask

    task automatic wait_idle(input int limit);
        int n;
        for (n = 0; n < limit; n++) begin
            addr = A_STATUS;
            #1;
            if (!read_data[0] && read_data[2]) break;
            tick();
        end
        check("drain_within_bound", {31'd0, (n < limit)}, 32'd1);
    endtask

    function automatic logic frame_bit(input logic [7:0] d, input int j);
        if (j == 0) return 1'b0;
        if (j <= 8) return d[j-1];
        return 1'b1;
    endfunction

    // Monitor: on each start bit, pops the next expected frame and checks every cycle.
    initial begin : monitor
        logic   prev;
        frame_t f;
        int     bad;
        bit     aborted;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b1;
            end else if (prev && tx === 1'b0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got a start bit, required none queued");
                    prev = 1'b0;
                end else begin
                    f       = exp_q.pop_front();
                    bad     = 0;
                    aborted = 1'b0;
                    for (int k = 1; k <= 10 * f.div; k++) begin
                        @(negedge clk);
                        if (rst) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (tx !== frame_bit(f.data, k / f.div)) bad++;
                    end
                    if (aborted) begin
                        $display("frame data=0x%02h div=%0d aborted by reset", f.data, f.div);
                    end else begin
                        checks++;
                        if (bad != 0) begin
                            errors++;
                            $display("FAIL frame_0x%02h: got %0d wrong tx samples, required 0", f.data, bad);
                        end else begin
                            $display("frame data=0x%02h div=%0d ok", f.data, f.div);
                        end
                    end
                    prev = 1'b1;
                end
            end else begin
                prev = tx;
            end
        end
    end

    initial begin : watchdog
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got no completion in 60000 cycles, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int highs;
        rst          = 1'b1;
        addr         = 32'd0;
        write_data   = 32'd0;
        write_enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset defaults and register map
        check("reset_tx", {31'd0, tx}, 32'd1);
        reg_check("reset_status", A_STATUS, 32'h0000_0004);
        reg_check("reset_divisor", A_DIVISOR, 32'd16);
        reg_check("txdata_reads_zero", A_TXDATA, 32'd0);
        bus_write(A_DIVISOR, 32'hFFFF_1234);
        reg_check("divisor_low_half", A_DIVISOR, 32'h0000_1234);
        bus_write(32'h1000_0006, 32'h0000_00AA);
        reg_check("unmapped_write_ignored", A_DIVISOR, 32'h0000_1234);
        reg_check("unselected_reads_zero", 32'h2000_0004, 32'd0);
        reg_check("no_push_from_unmapped", A_STATUS, 32'h0000_0004);
`ifndef UART_TX_IRQ_EN
        bus_write(A_IRQ_EN, 32'h3);
        reg_check("irq_en_absent", A_IRQ_EN, 32'd0);
`endif

        // Single byte at divisor 4
        bus_write(A_DIVISOR, 32'd4);
        send_timed(8'h55, 4, 40);

        // Divisor zero behaves as one cycle per bit
        bus_write(A_DIVISOR, 32'd0);
        reg_check("divisor_zero_readback", A_DIVISOR, 32'd0);
        send_timed(8'hA3, 1, 10);

        // Overflow: first byte pops at once, eight fill the FIFO, the tenth drops
        bus_write(A_DIVISOR, 32'd100);
        for (int i = 0; i < 10; i++) send(8'h10 + 8'(i), 100, i < 9);
        reg_check("overflow_status", A_STATUS, 32'h0000_080B);
        bus_write(A_STATUS, 32'h8);
        reg_check("overflow_cleared", A_STATUS, 32'h0000_0803);
        wait_idle(12000);
        tick();
        check("overflow_frames_seen", exp_q.size(), 32'd0);

        // Reset during data bit 3
        bus_write(A_DIVISOR, 32'd4);
        send(8'hF0, 4, 1'b1);
        repeat (18) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        check("midframe_reset_tx", {31'd0, tx}, 32'd1);
        reg_check("midframe_reset_status", A_STATUS, 32'h0000_0004);
        reg_check("midframe_reset_divisor", A_DIVISOR, 32'd16);
        highs = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (tx === 1'b1) highs++;
        end
        check("no_residual_frame", highs, 32'd60);

`ifdef UART_TX_IRQ_EN
        check("irq_reset", {31'd0, irq}, 32'd0);
        bus_write(A_IRQ_EN, 32'h1);
        reg_check("irq_en_readback", A_IRQ_EN, 32'h1);
        tick();
        check("irq_empty_idle", {31'd0, irq}, 32'd1);
        bus_write(A_DIVISOR, 32'd2);
        send(8'h3C, 2, 1'b1);
        tick();
        check("irq_drops_on_push", {31'd0, irq}, 32'd0);
        for (int i = 0; i < 100; i++) begin
            addr = A_STATUS;
            #1;
            if (!read_data[0]) break;
            tick();
        end
        check("irq_low_at_idle_return", {31'd0, irq}, 32'd0);
        tick();
        check("irq_one_cycle_after_idle", {31'd0, irq}, 32'd1);

        bus_write(A_IRQ_EN, 32'h2);
        bus_write(A_DIVISOR, 32'd20);
        for (int i = 0; i < 10; i++) send(8'hC0 + 8'(i), 20, i < 9);
        tick();
        check("irq_overflow", {31'd0, irq}, 32'd1);
        bus_write(A_STATUS, 32'h8);
        tick();
        check("irq_overflow_cleared", {31'd0, irq}, 32'd0);
        wait_idle(3000);
        tick();
        check("irq_frames_seen", exp_q.size(), 32'd0);
`endif

        repeat (5) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
